// File: rtl/sel_ctrl_if.sv
// Selector bus: raw pushbuttons, wrap mode and data inputs toward the selector;
// selected bit, current index and change strobe back to the datapath.
interface sel_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned SW = $clog2(WIDTH);

   logic [1:0]       pb;
   logic             wrap;
   logic [WIDTH-1:0] in;
   logic             out;
   logic [SW-1:0]    sel;
   logic             changed;

   modport master (output pb, wrap, in, input out, sel, changed);
   modport slave  (input pb, wrap, in, output out, sel, changed);
endinterface

// File: rtl/sel_ctrl.sv
// Pushbutton-driven input selector: synchronise and debounce two active-low buttons,
// step an index up/down/home on press events. SEL_CTRL_AUTOREPEAT_EN adds hold auto-repeat.
module sel_ctrl #(
   parameter int unsigned WIDTH           = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
`ifdef SEL_CTRL_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000
`endif
) (
   input  logic      clk,
   input  logic      rst_n,
   sel_ctrl_if.slave bus
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] SEL_MAX = SW'(WIDTH - 1);

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_DOWN,
      STEP_UP,
      STEP_HOME
   } step_e;

   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    stable_lvl;
   logic [1:0]    stable_prev_q;
   logic [1:0]    press;
   logic [SW-1:0] sel_q;
   logic [SW-1:0] sel_d;
   logic          chg_pend_q;
   logic          changed_q;
   logic          rpt_fire_c;
   step_e         step_c;

   // Two-flop synchronisers, reset to the released level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= bus.pb;
         sync2_q <= sync1_q;
      end
   end

   // Per-button debouncer: accept a new level after DEBOUNCE_CYCLES disagreeing cycles
   for (genvar g = 0; g < 2; g++) begin : g_db
      logic [CW-1:0] cnt_q;
      logic          lvl_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q <= '0;
            lvl_q <= 1'b1;
         end else if (sync2_q[g] == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            lvl_q <= sync2_q[g];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end

      assign stable_lvl[g] = lvl_q;
   end

   assign press = stable_prev_q & ~stable_lvl;

`ifdef SEL_CTRL_AUTOREPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW      = $clog2(RPT_MAX + 1);

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_RATE
   } rpt_state_e;

   rpt_state_e    rpt_state_q;
   rpt_state_e    rpt_state_d;
   logic [RW-1:0] rpt_cnt_q;
   logic [RW-1:0] rpt_cnt_d;
   logic          one_low;

   assign one_low = ^stable_lvl;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rpt_state_q <= RPT_IDLE;
         rpt_cnt_q   <= '0;
      end else begin
         rpt_state_q <= rpt_state_d;
         rpt_cnt_q   <= rpt_cnt_d;
      end
   end

   // Hold timer starts at the press event; only a single held button repeats
   always_comb begin
      rpt_state_d = rpt_state_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_fire_c  = 1'b0;
      if (!one_low) begin
         rpt_state_d = RPT_IDLE;
         rpt_cnt_d   = '0;
      end else if (|press) begin
         rpt_state_d = RPT_DELAY;
         rpt_cnt_d   = RW'(1);
      end else begin
         case (rpt_state_q)
            RPT_DELAY: begin
               if (rpt_cnt_q == RW'(REPEAT_DELAY)) begin
                  rpt_fire_c  = 1'b1;
                  rpt_cnt_d   = RW'(1);
                  rpt_state_d = RPT_RATE;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + RW'(1);
               end
            end
            RPT_RATE: begin
               if (rpt_cnt_q == RW'(REPEAT_RATE)) begin
                  rpt_fire_c = 1'b1;
                  rpt_cnt_d  = RW'(1);
               end else begin
                  rpt_cnt_d = rpt_cnt_q + RW'(1);
               end
            end
            default: ;
         endcase
      end
   end
`else
   assign rpt_fire_c = 1'b0;
`endif

   // Press resolution: both buttons down homes, otherwise down has priority over up
   always_comb begin
      step_c = STEP_NONE;
      if (|press) begin
         if (~|stable_lvl) begin
            step_c = STEP_HOME;
         end else if (press[0]) begin
            step_c = STEP_DOWN;
         end else begin
            step_c = STEP_UP;
         end
      end else if (rpt_fire_c) begin
         step_c = stable_lvl[0] ? STEP_UP : STEP_DOWN;
      end
   end

   always_comb begin
      sel_d = sel_q;
      case (step_c)
         STEP_DOWN: begin
            if (sel_q == '0) begin
               sel_d = bus.wrap ? SEL_MAX : '0;
            end else begin
               sel_d = sel_q - SW'(1);
            end
         end
         STEP_UP: begin
            if (sel_q == SEL_MAX) begin
               sel_d = bus.wrap ? '0 : SEL_MAX;
            end else begin
               sel_d = sel_q + SW'(1);
            end
         end
         STEP_HOME: sel_d = SEL_MAX;
         default:   ;
      endcase
   end

   // Index register; the change strobe trails the new index by one cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_prev_q <= 2'b11;
         sel_q         <= SEL_MAX;
         chg_pend_q    <= 1'b0;
         changed_q     <= 1'b0;
      end else begin
         stable_prev_q <= stable_lvl;
         sel_q         <= sel_d;
         chg_pend_q    <= (sel_d != sel_q);
         changed_q     <= chg_pend_q;
      end
   end

   assign bus.sel     = sel_q;
   assign bus.changed = changed_q;
   assign bus.out     = bus.in[sel_q];

endmodule

// File: tb/tb_sel_ctrl.sv
// Bench for sel_ctrl: per-edge behavioural model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_sel_ctrl;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RR = 5;
`ifdef SEL_CTRL_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   sel_ctrl_if #(.WIDTH(W)) bus ();

   sel_ctrl #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D)
`ifdef SEL_CTRL_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit       m_init = 1'b0;
   int       m_sel;
   bit       m_changed, chg_next;
   bit [1:0] r1, r2, seen, m_stable, press_pend;
   int       run [2];
   int       hold;
   int       lows;
   int       nsel;

   function automatic int step_dn(input int s);
      if (s == 0) return bus.wrap ? W - 1 : 0;
      return s - 1;
   endfunction

   function automatic int step_up(input int s);
      if (s == W - 1) return bus.wrap ? 0 : W - 1;
      return s + 1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_init     = 1'b1;
         m_sel      = W - 1;
         m_changed  = 1'b0;
         chg_next   = 1'b0;
         r1         = 2'b11;
         r2         = 2'b11;
         m_stable   = 2'b11;
         press_pend = 2'b00;
         run[0]     = 0;
         run[1]     = 0;
         hold       = -1;
      end else begin
         m_changed = chg_next;
         nsel      = m_sel;
         lows      = $countones(~m_stable);
         if (press_pend != 2'b00) begin
            if (lows == 2)          nsel = W - 1;
            else if (press_pend[0]) nsel = step_dn(m_sel);
            else                    nsel = step_up(m_sel);
            hold = (lows == 1) ? 0 : -1;
         end else if (hold >= 0 && lows == 1) begin
            hold++;
            if (AR && (hold == RD || (hold > RD && (hold - RD) % RR == 0)))
               nsel = m_stable[0] ? step_up(m_sel) : step_dn(m_sel);
         end else begin
            hold = -1;
         end
         chg_next = (nsel != m_sel);
         m_sel    = nsel;
         // button seen by the debouncer lags the pin by two edges
         seen       = r2;
         r2         = r1;
         r1         = bus.pb;
         press_pend = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (seen[i] != m_stable[i]) begin
               run[i]++;
               if (run[i] == D) begin
                  m_stable[i] = seen[i];
                  run[i]      = 0;
                  if (!seen[i]) press_pend[i] = 1'b1;
               end
            end else begin
               run[i] = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_init && rst_n) begin
         check("sel_model", int'(bus.sel), m_sel);
         check("changed_model", int'(bus.changed), int'(m_changed));
         check("out_model", int'(bus.out), int'(bus.in[m_sel]));
         if (bus.changed === 1'b1) n_pulses++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic press(input logic [1:0] b);
      bus.pb = b;
      cyc(10);
      bus.pb = 2'b11;
      cyc(10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      bus.pb   = 2'b11;
      bus.wrap = 1'b1;
      bus.in   = 16'h8000;
      rst_n    = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(1);
      check("reset_sel", int'(bus.sel), 15);
      check("reset_out", int'(bus.out), 1);
      check("reset_changed", int'(bus.changed), 0);

      // single step: one decrement, 7 edges after the pin edge
      bus.in = 16'h4000;
      #1;
      check("out_zero_latency", int'(bus.out), 0);
      p0     = n_pulses;
      bus.pb = 2'b10;
      cyc(6);
      check("step_not_yet", int'(bus.sel), 15);
      cyc(1);
      check("step_sel", int'(bus.sel), 14);
      check("step_out", int'(bus.out), 1);
      check("step_changed_lag", int'(bus.changed), 0);
      cyc(1);
      check("step_changed", int'(bus.changed), 1);
      cyc(1);
      check("step_changed_end", int'(bus.changed), 0);
      cyc(1);
      bus.pb = 2'b11;
      cyc(10);
      check("step_held_once", int'(bus.sel), 14);
      check("step_pulses", n_pulses - p0, 1);

      // bounce shorter than the debounce window
      bus.in = 16'hA5C3;
      p0     = n_pulses;
      for (int k = 0; k < 5; k++) begin
         bus.pb = 2'b01;
         cyc(2);
         bus.pb = 2'b11;
         cyc(2);
      end
      cyc(8);
      check("bounce_sel", int'(bus.sel), 14);
      check("bounce_pulses", n_pulses - p0, 0);

      // wrap and saturate at the top
      press(2'b01);
      check("up_to_15", int'(bus.sel), 15);
      press(2'b01);
      check("wrap_up", int'(bus.sel), 0);
      press(2'b10);
      check("wrap_down", int'(bus.sel), 15);
      bus.wrap = 1'b0;
      p0       = n_pulses;
      press(2'b01);
      check("sat_up", int'(bus.sel), 15);
      check("sat_up_pulses", n_pulses - p0, 0);

      // home from 3, same-cycle presses
      bus.wrap = 1'b1;
      for (int k = 0; k < 4; k++) press(2'b01);
      check("reach_3", int'(bus.sel), 3);
      press(2'b00);
      check("home_same_cycle", int'(bus.sel), 15);

      // home with the second press 10 cycles later
      for (int k = 0; k < 4; k++) press(2'b01);
      bus.pb = 2'b10;
      cyc(10);
      check("home_first_step", int'(bus.sel), 2);
      bus.pb = 2'b00;
      cyc(6);
      check("home_pending", int'(bus.sel), 2);
      cyc(1);
      check("home_late", int'(bus.sel), 15);
      bus.pb = 2'b11;
      cyc(12);

      // saturate at the bottom
      press(2'b01);
      bus.wrap = 1'b0;
      p0       = n_pulses;
      press(2'b10);
      check("sat_down", int'(bus.sel), 0);
      check("sat_down_pulses", n_pulses - p0, 0);

      // long hold of up from 0: press event 7 edges in, release seen 38 edges after it
      bus.in = 16'h0030;
      bus.pb = 2'b01;
      cyc(39);
      check("hold_mid", int'(bus.sel), AR ? 4 : 1);
      bus.pb = 2'b11;
      cyc(10);
      check("hold_final", int'(bus.sel), AR ? 5 : 1);
      check("hold_out", int'(bus.out), AR ? 1 : 0);

      // reset in the middle of a debounce restarts it from scratch
      bus.pb = 2'b10;
      cyc(4);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      check("rst_mid_sel", int'(bus.sel), 15);
      check("rst_mid_changed", int'(bus.changed), 0);
      cyc(5);
      check("rst_restart_wait", int'(bus.sel), 15);
      cyc(1);
      check("rst_restart_step", int'(bus.sel), 14);
      bus.pb = 2'b11;
      cyc(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
